// File: rtl/sap_control_sequencer.sv
// SAP-1 style control sequencer: steps fetch/execute T-states, decodes the opcode
// and issues the per-cycle control word, keeping its own Zero/Carry flag register.
module sap_control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic [1:0] alu_flags,
    output logic [1:0] alu_op,
    output logic       alu_out,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ram_in,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       out_in,
    output logic       zero_flag,
    output logic       carry_flag,
    output logic [2:0] tstate,
    output logic       halted
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_e;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_INC = 4'b1001;
    localparam logic [3:0] OP_DCR = 4'b1010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_INC = 2'b10;
    localparam logic [1:0] ALU_DCR = 2'b11;

    tstate_e tstate_q, tstate_d;
    logic    halted_q, halted_d;
    logic    zero_q, zero_d;
    logic    carry_q, carry_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            tstate_q <= T0;
            halted_q <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            halted_q <= halted_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    // Each instruction returns to T0 after its last step; HLT parks the counter at T2.
    always_comb begin
        tstate_d = tstate_q;
        halted_d = halted_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        if (!halted_q) begin
            case (tstate_q)
                T0: tstate_d = T1;
                T1: tstate_d = T2;
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: tstate_d = T3;
                        OP_HLT: halted_d = 1'b1;
                        OP_INC, OP_DCR: begin
                            zero_d   = alu_flags[1];
                            carry_d  = alu_flags[0];
                            tstate_d = T0;
                        end
                        default: tstate_d = T0;
                    endcase
                end
                T3: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        tstate_d = T4;
                    end else begin
                        tstate_d = T0;
                    end
                end
                T4: begin
                    zero_d   = alu_flags[1];
                    carry_d  = alu_flags[0];
                    tstate_d = T0;
                end
                default: tstate_d = T0;
            endcase
        end
    end

    always_comb begin
        alu_op  = ALU_ADD;
        alu_out = 1'b0;
        pc_out  = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        mar_in  = 1'b0;
        ram_out = 1'b0;
        ram_in  = 1'b0;
        ir_in   = 1'b0;
        ir_out  = 1'b0;
        a_in    = 1'b0;
        a_out   = 1'b0;
        b_in    = 1'b0;
        out_in  = 1'b0;
        if (!rst && !halted_q) begin
            case (tstate_q)
                T0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                T1: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    pc_inc  = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                        end
                        OP_LDI: begin
                            ir_out = 1'b1;
                            a_in   = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_load = 1'b1;
                        end
                        OP_JC: begin
                            ir_out  = 1'b1;
                            pc_load = carry_q;
                        end
                        OP_JZ: begin
                            ir_out  = 1'b1;
                            pc_load = zero_q;
                        end
                        OP_INC: begin
                            alu_op  = ALU_INC;
                            alu_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        OP_DCR: begin
                            alu_op  = ALU_DCR;
                            alu_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        OP_OUT: begin
                            a_out  = 1'b1;
                            out_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                        end
                        OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    alu_op  = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
                    alu_out = 1'b1;
                    a_in    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign tstate     = tstate_q;
    assign halted     = halted_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;

endmodule
